// File: rtl/msx_keyboard_matrix.sv
// MSX1 keyboard matrix responder: decodes PS/2 set-2 bytes into an active-low
// key matrix and returns the column byte for the row the PPI selects.
module msx_keyboard_matrix #(
    parameter int unsigned ROWS       = 11,
    parameter int unsigned PAUSE_SKIP = 7
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_kbd_data,
    input  logic       i_kbd_valid,
    input  logic [3:0] i_row_sel,
    output logic [7:0] o_cols,
    output logic       o_key_event
);

    typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StSkip} state_t;

    state_t     r_state;
    logic [7:0] r_skip_cnt;
    logic [7:0] r_matrix [ROWS];
    logic       r_lshift;
    logic       r_rshift;
    logic       r_key_event;
    logic [7:0] r_cols;

    logic       w_make;
    logic       w_brk;
    logic       w_ext;
    logic [7:0] w_lut;
    logic [3:0] w_row;
    logic [2:0] w_bit;
    logic       w_map_hit;
    logic       w_cur_bit;
    logic       w_map_evt;
    logic       w_lshift_d;
    logic       w_rshift_d;
    logic       w_shift_evt;
    logic [7:0] w_row_val;

    // {ext,code} -> {hit, row[3:0], bit[2:0]}; shift keys are handled separately
    function automatic logic [7:0] lut(input logic [8:0] key);
        lut = 8'h00;
        case (key)
            9'h045: lut = {1'b1, 4'd0, 3'd0};  9'h016: lut = {1'b1, 4'd0, 3'd1};
            9'h01E: lut = {1'b1, 4'd0, 3'd2};  9'h026: lut = {1'b1, 4'd0, 3'd3};
            9'h025: lut = {1'b1, 4'd0, 3'd4};  9'h02E: lut = {1'b1, 4'd0, 3'd5};
            9'h036: lut = {1'b1, 4'd0, 3'd6};  9'h03D: lut = {1'b1, 4'd0, 3'd7};
            9'h03E: lut = {1'b1, 4'd1, 3'd0};  9'h046: lut = {1'b1, 4'd1, 3'd1};
            9'h04E: lut = {1'b1, 4'd1, 3'd2};  9'h055: lut = {1'b1, 4'd1, 3'd3};
            9'h05D: lut = {1'b1, 4'd1, 3'd4};  9'h054: lut = {1'b1, 4'd1, 3'd5};
            9'h05B: lut = {1'b1, 4'd1, 3'd6};  9'h04C: lut = {1'b1, 4'd1, 3'd7};
            9'h052: lut = {1'b1, 4'd2, 3'd0};  9'h00E: lut = {1'b1, 4'd2, 3'd1};
            9'h041: lut = {1'b1, 4'd2, 3'd2};  9'h049: lut = {1'b1, 4'd2, 3'd3};
            9'h04A: lut = {1'b1, 4'd2, 3'd4};  9'h01C: lut = {1'b1, 4'd2, 3'd6};
            9'h032: lut = {1'b1, 4'd2, 3'd7};
            9'h021: lut = {1'b1, 4'd3, 3'd0};  9'h023: lut = {1'b1, 4'd3, 3'd1};
            9'h024: lut = {1'b1, 4'd3, 3'd2};  9'h02B: lut = {1'b1, 4'd3, 3'd3};
            9'h034: lut = {1'b1, 4'd3, 3'd4};  9'h033: lut = {1'b1, 4'd3, 3'd5};
            9'h043: lut = {1'b1, 4'd3, 3'd6};  9'h03B: lut = {1'b1, 4'd3, 3'd7};
            9'h042: lut = {1'b1, 4'd4, 3'd0};  9'h04B: lut = {1'b1, 4'd4, 3'd1};
            9'h03A: lut = {1'b1, 4'd4, 3'd2};  9'h031: lut = {1'b1, 4'd4, 3'd3};
            9'h044: lut = {1'b1, 4'd4, 3'd4};  9'h04D: lut = {1'b1, 4'd4, 3'd5};
            9'h015: lut = {1'b1, 4'd4, 3'd6};  9'h02D: lut = {1'b1, 4'd4, 3'd7};
            9'h01B: lut = {1'b1, 4'd5, 3'd0};  9'h02C: lut = {1'b1, 4'd5, 3'd1};
            9'h03C: lut = {1'b1, 4'd5, 3'd2};  9'h02A: lut = {1'b1, 4'd5, 3'd3};
            9'h01D: lut = {1'b1, 4'd5, 3'd4};  9'h022: lut = {1'b1, 4'd5, 3'd5};
            9'h035: lut = {1'b1, 4'd5, 3'd6};  9'h01A: lut = {1'b1, 4'd5, 3'd7};
            9'h014: lut = {1'b1, 4'd6, 3'd1};  9'h114: lut = {1'b1, 4'd6, 3'd1};
            9'h011: lut = {1'b1, 4'd6, 3'd2};  9'h058: lut = {1'b1, 4'd6, 3'd3};
            9'h111: lut = {1'b1, 4'd6, 3'd4};  9'h005: lut = {1'b1, 4'd6, 3'd5};
            9'h006: lut = {1'b1, 4'd6, 3'd6};  9'h004: lut = {1'b1, 4'd6, 3'd7};
            9'h00C: lut = {1'b1, 4'd7, 3'd0};  9'h003: lut = {1'b1, 4'd7, 3'd1};
            9'h076: lut = {1'b1, 4'd7, 3'd2};  9'h00D: lut = {1'b1, 4'd7, 3'd3};
            9'h00A: lut = {1'b1, 4'd7, 3'd4};  9'h066: lut = {1'b1, 4'd7, 3'd5};
            9'h083: lut = {1'b1, 4'd7, 3'd6};  9'h05A: lut = {1'b1, 4'd7, 3'd7};
            9'h15A: lut = {1'b1, 4'd7, 3'd7};
            9'h029: lut = {1'b1, 4'd8, 3'd0};  9'h16C: lut = {1'b1, 4'd8, 3'd1};
            9'h170: lut = {1'b1, 4'd8, 3'd2};  9'h171: lut = {1'b1, 4'd8, 3'd3};
            9'h16B: lut = {1'b1, 4'd8, 3'd4};  9'h175: lut = {1'b1, 4'd8, 3'd5};
            9'h172: lut = {1'b1, 4'd8, 3'd6};  9'h174: lut = {1'b1, 4'd8, 3'd7};
            9'h07C: lut = {1'b1, 4'd9, 3'd0};  9'h079: lut = {1'b1, 4'd9, 3'd1};
            9'h14A: lut = {1'b1, 4'd9, 3'd2};  9'h070: lut = {1'b1, 4'd9, 3'd3};
            9'h069: lut = {1'b1, 4'd9, 3'd4};  9'h072: lut = {1'b1, 4'd9, 3'd5};
            9'h07A: lut = {1'b1, 4'd9, 3'd6};  9'h06B: lut = {1'b1, 4'd9, 3'd7};
            9'h073: lut = {1'b1, 4'd10, 3'd0}; 9'h074: lut = {1'b1, 4'd10, 3'd1};
            9'h06C: lut = {1'b1, 4'd10, 3'd2}; 9'h075: lut = {1'b1, 4'd10, 3'd3};
            9'h07D: lut = {1'b1, 4'd10, 3'd4}; 9'h07B: lut = {1'b1, 4'd10, 3'd5};
            9'h071: lut = {1'b1, 4'd10, 3'd7};
            default: lut = 8'h00;
        endcase
    endfunction

    // Decode the incoming byte into a make/break action and its matrix effect
    always_comb begin
        w_make = 1'b0;
        w_brk  = 1'b0;
        w_ext  = 1'b0;
        if (i_kbd_valid) begin
            case (r_state)
                StIdle: begin
                    if (!(i_kbd_data inside {8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE}))
                        w_make = 1'b1;
                end
                StExt: begin
                    if (!(i_kbd_data inside {8'hF0, 8'h12, 8'h59})) begin
                        w_make = 1'b1;
                        w_ext  = 1'b1;
                    end
                end
                StBrk: w_brk = 1'b1;
                StExtBrk: begin
                    if (!(i_kbd_data inside {8'h12, 8'h59})) begin
                        w_brk = 1'b1;
                        w_ext = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        w_lut     = lut({w_ext, i_kbd_data});
        w_row     = w_lut[6:3];
        w_bit     = w_lut[2:0];
        w_map_hit = w_lut[7] && (32'(w_row) < ROWS) && (w_make || w_brk);
        w_cur_bit = w_map_hit ? r_matrix[w_row][w_bit] : 1'b1;
        // New bit value equals w_brk, so a toggle is any difference from it
        w_map_evt = w_map_hit && (w_cur_bit != w_brk);

        w_lshift_d = r_lshift;
        w_rshift_d = r_rshift;
        if ((w_make || w_brk) && !w_ext && i_kbd_data == 8'h12) w_lshift_d = w_make;
        if ((w_make || w_brk) && !w_ext && i_kbd_data == 8'h59) w_rshift_d = w_make;
        w_shift_evt = (w_lshift_d | w_rshift_d) != (r_lshift | r_rshift);
    end

    // Prefix FSM, matrix/shift state and key-event pulse
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_skip_cnt  <= 8'd0;
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_key_event <= 1'b0;
            for (int i = 0; i < int'(ROWS); i++) r_matrix[i] <= 8'hFF;
        end else begin
            r_key_event <= w_map_evt || w_shift_evt;
            r_lshift    <= w_lshift_d;
            r_rshift    <= w_rshift_d;
            if (w_map_hit) r_matrix[w_row][w_bit] <= w_brk;
            if (i_kbd_valid) begin
                case (r_state)
                    StIdle: begin
                        if (i_kbd_data == 8'hE0) r_state <= StExt;
                        else if (i_kbd_data == 8'hF0) r_state <= StBrk;
                        else if (i_kbd_data == 8'hE1) begin
                            r_state    <= StSkip;
                            r_skip_cnt <= 8'(PAUSE_SKIP);
                        end
                    end
                    StExt:    r_state <= (i_kbd_data == 8'hF0) ? StExtBrk : StIdle;
                    StBrk:    r_state <= StIdle;
                    StExtBrk: r_state <= StIdle;
                    StSkip: begin
                        r_skip_cnt <= (r_skip_cnt == 8'd0) ? 8'd0 : r_skip_cnt - 8'd1;
                        if (r_skip_cnt <= 8'd1) r_state <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    // Selected row with the shared shift bit overlaid on r6b0
    always_comb begin
        w_row_val = 8'hFF;
        if (32'(i_row_sel) < ROWS) begin
            w_row_val = r_matrix[i_row_sel];
            if (i_row_sel == 4'd6) w_row_val[0] = ~(r_lshift | r_rshift);
        end
    end

    // Registered column output, one cycle behind row_sel
    always_ff @(posedge i_clk) begin
        if (i_reset) r_cols <= 8'hFF;
        else         r_cols <= w_row_val;
    end

    assign o_cols      = r_cols;
    assign o_key_event = r_key_event;

endmodule

// File: tb/tb_msx_keyboard_matrix.sv
// Scoreboard bench for msx_keyboard_matrix: stimulus queues expected cols and
// key_event values with their due cycle; a monitor pops and compares them.
module tb_msx_keyboard_matrix;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_valid = 1'b0;
    logic [3:0] row_sel = 4'd0;
    logic [7:0] cols;
    logic       key_event;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int         due;
        bit         is_ev;
        logic [7:0] exp;
        string      name;
    } chk_t;

    chk_t sb[$];

    msx_keyboard_matrix #(
        .ROWS       (11),
        .PAUSE_SKIP (7)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_kbd_data  (kbd_data),
        .i_kbd_valid (kbd_valid),
        .i_row_sel   (row_sel),
        .o_cols      (cols),
        .o_key_event (key_event)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keep the scoreboard ordered by due cycle
    function automatic void push(input int due, input bit is_ev, input logic [7:0] exp,
                                 input string name);
        chk_t c;
        int   idx;
        c.due   = due;
        c.is_ev = is_ev;
        c.exp   = exp;
        c.name  = name;
        idx = sb.size();
        while (idx > 0 && sb[idx-1].due > due) idx--;
        sb.insert(idx, c);
    endfunction

    // Monitor: compare every expectation that falls due on this cycle
    always @(negedge clk) begin
        chk_t c;
        bit   ev_seen;
        ev_seen = 1'b0;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            c = sb.pop_front();
            n_tests++;
            if (c.due < cyc) begin
                n_fail++;
                $display("FAIL %s: check missed (due cycle %0d, now %0d)", c.name, c.due, cyc);
            end else if (c.is_ev) begin
                ev_seen = 1'b1;
                if (key_event !== c.exp[0]) begin
                    n_fail++;
                    $display("FAIL %s: key_event=%b required %b", c.name, key_event, c.exp[0]);
                end
            end else if (cols !== c.exp) begin
                n_fail++;
                $display("FAIL %s: cols=%02h required %02h (row_sel=%0d)", c.name, cols, c.exp,
                         row_sel);
            end
        end
        if (!ev_seen && key_event === 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_key_event: key_event=1 required 0 at cycle %0d", cyc);
        end
    end

    // Drive one byte for one cycle; key_event answers on the following cycle
    task automatic send(input logic [7:0] b, input bit ev, input string nm);
        kbd_data  = b;
        kbd_valid = 1'b1;
        push(cyc + 1, 1'b1, {7'd0, ev}, $sformatf("%s_ev_%02h", nm, b));
        @(negedge clk);
        kbd_valid = 1'b0;
    endtask

    task automatic check_cols(input logic [7:0] e, input string nm);
        push(cyc + 1, 1'b0, e, nm);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: reset state, every row idle
        push(cyc + 1, 1'b1, 8'h00, "reset_ev");
        for (int r = 0; r < 16; r++) begin
            row_sel = 4'(r);
            check_cols(8'hFF, $sformatf("reset_row%0d", r));
        end

        // 2: 'A' make, typematic repeat, break
        row_sel = 4'd2;
        send(8'h1C, 1'b1, "a_make");
        check_cols(8'hBF, "a_pressed");
        send(8'h1C, 1'b0, "a_repeat");
        check_cols(8'hBF, "a_repeat_held");
        send(8'hF0, 1'b0, "a_brk_pfx");
        send(8'h1C, 1'b1, "a_brk");
        check_cols(8'hFF, "a_released");

        // 3: extended UP make/break; plain 75 is keypad 8, not UP
        row_sel = 4'd8;
        send(8'hE0, 1'b0, "up_pfx");
        send(8'h75, 1'b1, "up_make");
        check_cols(8'hDF, "up_pressed");
        send(8'hE0, 1'b0, "up_brk_pfx0");
        send(8'hF0, 1'b0, "up_brk_pfx1");
        send(8'h75, 1'b1, "up_brk");
        check_cols(8'hFF, "up_released");
        send(8'h75, 1'b1, "kp8_make");
        check_cols(8'hFF, "kp8_row8_unchanged");
        row_sel = 4'd10;
        check_cols(8'hF7, "kp8_row10");
        send(8'hF0, 1'b0, "kp8_brk_pfx");
        send(8'h75, 1'b1, "kp8_brk");
        check_cols(8'hFF, "kp8_released");

        // 4: two shifts share r6b0
        row_sel = 4'd6;
        send(8'h12, 1'b1, "lshift_make");
        send(8'h59, 1'b0, "rshift_make");
        send(8'hF0, 1'b0, "lshift_brk_pfx");
        send(8'h12, 1'b0, "lshift_brk");
        check_cols(8'hFE, "shift_held_by_r");
        send(8'hF0, 1'b0, "rshift_brk_pfx");
        send(8'h59, 1'b1, "rshift_brk");
        check_cols(8'hFF, "shift_released");

        // 5: Pause sequence tail is swallowed, then '1' works
        row_sel = 4'd0;
        send(8'hE1, 1'b0, "pause0");
        send(8'h14, 1'b0, "pause1");
        send(8'h77, 1'b0, "pause2");
        send(8'hE1, 1'b0, "pause3");
        send(8'hF0, 1'b0, "pause4");
        send(8'h14, 1'b0, "pause5");
        send(8'hF0, 1'b0, "pause6");
        send(8'h77, 1'b0, "pause7");
        send(8'h16, 1'b1, "one_make");
        check_cols(8'hFD, "one_pressed");
        row_sel = 4'd6;
        check_cols(8'hFF, "ctrl_untouched");
        send(8'hF0, 1'b0, "one_brk_pfx");
        send(8'h16, 1'b1, "one_brk");

        // 6: reset clears matrix and a pending E0 prefix
        row_sel = 4'd2;
        send(8'h1C, 1'b1, "pre_rst_a");
        send(8'hE0, 1'b0, "pre_rst_pfx");
        pulse_reset();
        check_cols(8'hFF, "rst_row2_cleared");
        row_sel = 4'd8;
        send(8'h29, 1'b1, "space_make");
        check_cols(8'hFE, "space_pressed");

        repeat (3) @(negedge clk);
        while (sb.size() > 0) begin
            chk_t c;
            c = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: never compared (due cycle %0d)", c.name, c.due);
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
